// File: rtl/tl_pkg.sv
// Shared definitions for the junction phase scheduler: state codes, lamp encodings,
// default phase durations and the state-to-lamp decode.
package tl_pkg;

  typedef enum logic [3:0] {
    AR_INIT = 4'd0,
    MAIN_G  = 4'd1,
    M2_Y    = 4'd2,
    TURN_G  = 4'd3,
    TURN_Y  = 4'd4,
    MAIN_Y  = 4'd5,
    AR_MAIN = 4'd6,
    SIDE_G  = 4'd7,
    SIDE_Y  = 4'd8,
    AR_SIDE = 4'd9
  } state_t;

  localparam logic [2:0] LT_R = 3'b100;
  localparam logic [2:0] LT_Y = 3'b010;
  localparam logic [2:0] LT_G = 3'b001;

  localparam int T_MAIN_MIN_DEF = 10;
  localparam int T_Y_DEF        = 3;
  localparam int T_AR_DEF       = 1;
  localparam int T_TURN_DEF     = 8;
  localparam int T_SIDE_DEF     = 10;

  typedef struct packed {
    logic [2:0] m1;
    logic [2:0] m2;
    logic [2:0] mt;
    logic [2:0] s;
  } heads_t;

  function automatic heads_t heads_of(input state_t st);
    heads_t h;
    h.m1 = LT_R;
    h.m2 = LT_R;
    h.mt = LT_R;
    h.s  = LT_R;
    case (st)
      MAIN_G:  begin h.m1 = LT_G; h.m2 = LT_G; end
      M2_Y:    begin h.m1 = LT_G; h.m2 = LT_Y; end
      TURN_G:  begin h.m1 = LT_G; h.mt = LT_G; end
      TURN_Y:  begin h.m1 = LT_Y; h.mt = LT_Y; end
      MAIN_Y:  begin h.m1 = LT_Y; h.m2 = LT_Y; end
      SIDE_G:  h.s = LT_G;
      SIDE_Y:  h.s = LT_Y;
      default: ;
    endcase
    return h;
  endfunction

  // The debug port is only 3 bits wide, so the three all-red states share code 0.
  function automatic logic [2:0] phase_of(input state_t st);
    logic [2:0] p;
    p = 3'd0;
    case (st)
      MAIN_G:  p = 3'd1;
      M2_Y:    p = 3'd2;
      TURN_G:  p = 3'd3;
      TURN_Y:  p = 3'd4;
      MAIN_Y:  p = 3'd5;
      SIDE_G:  p = 3'd6;
      SIDE_Y:  p = 3'd7;
      default: p = 3'd0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/tl_phase_timer.sv
// Down-counter for phase dwell: load a value, count down to zero and hold there.
module tl_phase_timer #(
  parameter int TW = 8
) (
  input  logic          clk,
  input  logic          r_n,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  output logic [TW-1:0] value,
  output logic          zero
);

  always_ff @(posedge clk or negedge r_n) begin
    if (!r_n) begin
      value <= '0;
    end else if (load) begin
      value <= load_val;
    end else if (value != '0) begin
      value <= value - 1'b1;
    end
  end

  assign zero = (value == '0);

endmodule

// File: rtl/tl_phase_sched.sv
// Request-driven phase scheduler for the four-head junction with latched side/turn
// demand and emergency parking in MAIN_G.
module tl_phase_sched
  import tl_pkg::*;
#(
  parameter int TW         = 8,
  parameter int T_MAIN_MIN = T_MAIN_MIN_DEF,
  parameter int T_Y        = T_Y_DEF,
  parameter int T_AR       = T_AR_DEF,
  parameter int T_TURN     = T_TURN_DEF,
  parameter int T_SIDE     = T_SIDE_DEF
) (
  input  logic       clk,
  input  logic       r_n,
  input  logic       side_req,
  input  logic       turn_req,
  input  logic       emg,
  output logic [2:0] m1,
  output logic [2:0] m2,
  output logic [2:0] mt,
  output logic [2:0] s,
  output logic [2:0] phase,
  output logic       emg_act
);

  localparam logic [TW-1:0] LD_MAIN = TW'(T_MAIN_MIN - 1);
  localparam logic [TW-1:0] LD_Y    = TW'(T_Y - 1);
  localparam logic [TW-1:0] LD_AR   = TW'(T_AR - 1);
  localparam logic [TW-1:0] LD_TURN = TW'(T_TURN - 1);
  localparam logic [TW-1:0] LD_SIDE = TW'(T_SIDE - 1);

  state_t          state_reg;
  state_t          state_next;
  logic            turn_lat_reg;
  logic            side_lat_reg;
  logic            t_load;
  logic [TW-1:0]   t_load_val;
  logic [TW-1:0]   t_value;
  logic            t_zero;

  tl_phase_timer #(.TW(TW)) u_timer (
    .clk      (clk),
    .r_n      (r_n),
    .load     (t_load),
    .load_val (t_load_val),
    .value    (t_value),
    .zero     (t_zero)
  );

  // Yellow and all-red phases only ever leave on timer expiry; greens may be cut by emg.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      AR_INIT: if (t_zero) state_next = MAIN_G;
      MAIN_G: begin
        if (t_zero && !emg) begin
          if (turn_lat_reg)      state_next = M2_Y;
          else if (side_lat_reg) state_next = MAIN_Y;
        end
      end
      M2_Y:    if (t_zero)        state_next = TURN_G;
      TURN_G:  if (t_zero || emg) state_next = TURN_Y;
      TURN_Y:  if (t_zero)        state_next = AR_MAIN;
      MAIN_Y:  if (t_zero)        state_next = AR_MAIN;
      AR_MAIN: if (t_zero)        state_next = (side_lat_reg && !emg) ? SIDE_G : MAIN_G;
      SIDE_G:  if (t_zero || emg) state_next = SIDE_Y;
      SIDE_Y:  if (t_zero)        state_next = AR_SIDE;
      AR_SIDE: if (t_zero)        state_next = MAIN_G;
      default:                    state_next = AR_INIT;
    endcase
  end

  always_comb begin
    t_load = (state_next != state_reg);
    case (state_next)
      MAIN_G:                       t_load_val = LD_MAIN;
      M2_Y, TURN_Y, MAIN_Y, SIDE_Y: t_load_val = LD_Y;
      TURN_G:                       t_load_val = LD_TURN;
      SIDE_G:                       t_load_val = LD_SIDE;
      default:                      t_load_val = LD_AR;
    endcase
  end

  always_ff @(posedge clk or negedge r_n) begin
    if (!r_n) begin
      state_reg    <= AR_INIT;
      turn_lat_reg <= 1'b0;
      side_lat_reg <= 1'b0;
      m1           <= LT_R;
      m2           <= LT_R;
      mt           <= LT_R;
      s            <= LT_R;
      phase        <= 3'd0;
      emg_act      <= 1'b0;
    end else begin
      state_reg          <= state_next;
      {m1, m2, mt, s}    <= heads_of(state_next);
      phase              <= phase_of(state_next);
      // A latch is cleared on entry to its green and stays clear for the whole green.
      turn_lat_reg       <= (state_next == TURN_G) ? 1'b0 : (turn_lat_reg | turn_req);
      side_lat_reg       <= (state_next == SIDE_G) ? 1'b0 : (side_lat_reg | side_req);
      if (state_reg != MAIN_G && emg) begin
        emg_act <= 1'b1;
      end else if (state_reg == MAIN_G && !emg) begin
        emg_act <= 1'b0;
      end
    end
  end

endmodule
